// File: rtl/branch_predictor_if.sv
// Fetch/resolve interface of the gshare branch predictor.
// The master side is the core: it issues lookups from fetch and returns
// resolved branches from execute. The slave side is the predictor.
interface branch_predictor_if #(
  parameter int IDX_WIDTH = 6,
  parameter int CNT_WIDTH = 32
);
  // Fetch-stage lookup
  logic                 fetch_valid;
  logic [31:0]          fetch_pc;
  logic                 pred_valid;
  logic                 pred_taken;
  logic [IDX_WIDTH-1:0] pred_idx;

  // Execute-stage resolution
  logic                 resolve_valid;
  logic [IDX_WIDTH-1:0] resolve_idx;
  logic                 resolve_br_en;
  logic                 resolve_pred_taken;
  logic                 mispredict;

  // Statistics
  logic [CNT_WIDTH-1:0] branch_cnt;
  logic [CNT_WIDTH-1:0] mispredict_cnt;

  modport master (
    output fetch_valid, fetch_pc,
    output resolve_valid, resolve_idx, resolve_br_en, resolve_pred_taken,
    input  pred_valid, pred_taken, pred_idx,
    input  mispredict, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  fetch_valid, fetch_pc,
    input  resolve_valid, resolve_idx, resolve_br_en, resolve_pred_taken,
    output pred_valid, pred_taken, pred_idx,
    output mispredict, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Gshare direction predictor: a table of 2-bit saturating counters indexed by
// PC[IDX_WIDTH+1:2] XOR global history. Lookups return a registered guess one
// cycle later; resolutions from execute train the counters and the history in
// the same cycle and raise a combinational mispredict flag.
module branch_predictor #(
  parameter int IDX_WIDTH = 6,
  parameter int GHR_WIDTH = 6,
  parameter int CNT_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bp
);

  localparam int ENTRIES = 1 << IDX_WIDTH;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_state_e;

  ctr_state_e           ctr_q [ENTRIES];
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
  logic                 pred_valid_q, pred_valid_d;
  logic                 pred_taken_q, pred_taken_d;
  logic [IDX_WIDTH-1:0] pred_idx_q, pred_idx_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispredict_cnt_q, mispredict_cnt_d;

  logic [IDX_WIDTH-1:0] lookup_idx;
  ctr_state_e           upd_ctr;
  ctr_state_e           lookup_ctr;
  logic                 mispredict;

  // PC bits outside the index field do not take part in the hash.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.fetch_pc[31:IDX_WIDTH+2], bp.fetch_pc[1:0]};

  // One step of the saturating 2-bit counter: taken moves toward ST,
  // not-taken toward SNT.
  function automatic ctr_state_e ctr_step(input ctr_state_e cur, input logic taken);
    ctr_state_e nxt;
    nxt = cur;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  assign mispredict = bp.resolve_valid & (bp.resolve_br_en != bp.resolve_pred_taken);

  // Hash the fetch PC with pre-update history and pick the counter to report,
  // forwarding the counter being trained this cycle when the indices collide.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned, which would infer a latch.
    lookup_idx = bp.fetch_pc[IDX_WIDTH+1:2] ^ IDX_WIDTH'(ghr_q);
    upd_ctr    = ctr_step(ctr_q[bp.resolve_idx], bp.resolve_br_en);
    lookup_ctr = ctr_q[lookup_idx];
    if (bp.resolve_valid && (bp.resolve_idx == lookup_idx)) begin
      lookup_ctr = upd_ctr;
    end
  end

  // Next-state for the prediction registers, history and statistics.
  always_comb begin
    pred_valid_d     = bp.fetch_valid;
    pred_taken_d     = pred_taken_q;
    pred_idx_d       = pred_idx_q;
    ghr_d            = ghr_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;

    if (bp.fetch_valid) begin
      pred_taken_d = lookup_ctr[1];
      pred_idx_d   = lookup_idx;
    end

    if (bp.resolve_valid) begin
      ghr_d = (ghr_q << 1) | GHR_WIDTH'(bp.resolve_br_en);
      if (branch_cnt_q != '1) begin
        branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
      end
      if (mispredict && (mispredict_cnt_q != '1)) begin
        mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // State registers and pattern-table training; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the pattern table is reset entry by entry because a cold predictor must start every counter at weakly not-taken.
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= WNT;
      end
      ghr_q            <= '0;
      pred_valid_q     <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_idx_q       <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (bp.resolve_valid) begin
        ctr_q[bp.resolve_idx] <= upd_ctr;
      end
      ghr_q            <= ghr_d;
      pred_valid_q     <= pred_valid_d;
      pred_taken_q     <= pred_taken_d;
      pred_idx_q       <= pred_idx_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign bp.pred_valid     = pred_valid_q;
  assign bp.pred_taken     = pred_taken_q;
  assign bp.pred_idx       = pred_idx_q;
  assign bp.mispredict     = mispredict;
  assign bp.branch_cnt     = branch_cnt_q;
  assign bp.mispredict_cnt = mispredict_cnt_q;

endmodule
